// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types: response codes and the command-master FSM encoding.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RESP    = 3'd5
    } m_axi_cmd_state_t;

endpackage

// File: rtl/m_axi_cmd.sv
// AXI4-Lite master: one local command becomes one AW+W+B or AR+R transaction and one response.
// Optional hung-slave abort is compiled in with `M_AXI_CMD_TIMEOUT_EN.
module m_axi_cmd
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    areset,
    // Every channel below: a transfer happens on a rising edge where valid && ready;
    // a valid, once raised, stays high with a stable payload until that edge.
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic [1:0]              rsp_resp_o,
    output logic                    rsp_timeout_o,
    output logic [ADDR_WIDTH-1:0]   awaddr_o,
    output logic                    awvalid_o,
    input  logic                    awready_i,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [DATA_WIDTH/8-1:0] wstrb_o,
    output logic                    wvalid_o,
    input  logic                    wready_i,
    input  logic [1:0]              bresp_i,
    input  logic                    bvalid_i,
    output logic                    bready_o,
    output logic [ADDR_WIDTH-1:0]   araddr_o,
    output logic                    arvalid_o,
    input  logic                    arready_i,
    input  logic [DATA_WIDTH-1:0]   rdata_i,
    input  logic [1:0]              rresp_i,
    input  logic                    rvalid_i,
    output logic                    rready_o,
    output m_axi_cmd_state_t        dbg_state_o
);

    m_axi_cmd_state_t        r_state;
    logic                    r_cmd_ready;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic                    r_bready;
    logic                    r_arvalid;
    logic                    r_rready;
    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic [1:0]              r_rsp_resp;
    logic                    w_aw_done_nxt;
    logic                    w_w_done_nxt;

    // Completion as of this edge, so simultaneous AW/W handshakes leave WR_REQ at once.
    assign w_aw_done_nxt = r_aw_done | (r_awvalid & awready_i);
    assign w_w_done_nxt  = r_w_done  | (r_wvalid  & wready_i);

`ifdef M_AXI_CMD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_busy_cnt;
    logic             r_rsp_timeout;
    logic             w_busy;
    logic             w_timeout;

    assign w_busy = (r_state == ST_WR_REQ) || (r_state == ST_WR_RESP) ||
                    (r_state == ST_RD_REQ) || (r_state == ST_RD_DATA);
    // The counter would reach the limit on this edge: abort instead of counting further.
    assign w_timeout = w_busy && (r_busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_busy_cnt <= '0;
        end else if (r_state == ST_IDLE && cmd_valid_i) begin
            r_busy_cnt <= '0;
        end else if (w_busy) begin
            r_busy_cnt <= r_busy_cnt + 1'b1;
        end
    end

    assign rsp_timeout_o = r_rsp_timeout;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign rsp_timeout_o    = 1'b0;
`endif

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state       <= ST_IDLE;
            r_cmd_ready   <= 1'b1;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= '0;
`ifdef M_AXI_CMD_TIMEOUT_EN
            r_rsp_timeout <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        r_addr      <= cmd_addr_i;
                        r_wdata     <= cmd_wdata_i;
                        r_wstrb     <= cmd_wstrb_i;
                        r_cmd_ready <= 1'b0;
                        r_aw_done   <= 1'b0;
                        r_w_done    <= 1'b0;
`ifdef M_AXI_CMD_TIMEOUT_EN
                        r_rsp_timeout <= 1'b0;
`endif
                        if (cmd_write_i) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= ST_WR_REQ;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RD_REQ;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (r_awvalid && awready_i) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (r_wvalid && wready_i) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_done_nxt && w_w_done_nxt) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (bvalid_i) begin
                        r_bready    <= 1'b0;
                        r_rsp_resp  <= bresp_i;
                        r_rsp_rdata <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RD_REQ: begin
                    if (arready_i) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (rvalid_i) begin
                        r_rready    <= 1'b0;
                        r_rsp_rdata <= rdata_i;
                        r_rsp_resp  <= rresp_i;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                end
            endcase
`ifdef M_AXI_CMD_TIMEOUT_EN
            // Hung slave: drop every channel and report DECERR rather than wait forever.
            if (w_timeout) begin
                r_awvalid     <= 1'b0;
                r_wvalid      <= 1'b0;
                r_bready      <= 1'b0;
                r_arvalid     <= 1'b0;
                r_rready      <= 1'b0;
                r_rsp_resp    <= RESP_DECERR;
                r_rsp_rdata   <= '0;
                r_rsp_timeout <= 1'b1;
                r_rsp_valid   <= 1'b1;
                r_state       <= ST_RESP;
            end
`endif
        end
    end

    assign cmd_ready_o = r_cmd_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_resp_o  = r_rsp_resp;
    assign awaddr_o    = r_addr;
    assign araddr_o    = r_addr;
    assign awvalid_o   = r_awvalid;
    assign wdata_o     = r_wdata;
    assign wstrb_o     = r_wstrb;
    assign wvalid_o    = r_wvalid;
    assign bready_o    = r_bready;
    assign arvalid_o   = r_arvalid;
    assign rready_o    = r_rready;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_m_axi_cmd.sv
// Randomized bench for m_axi_cmd: a 5-word AXI4-Lite slave with programmable waits,
// a memory-level reference model and an expected-response queue.
`timescale 1ns/1ps
module tb_m_axi_cmd;
    import axi_lite_pkg::*;

    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              areset = 1'b1;
    logic              cmd_valid_i = 1'b0;
    logic              cmd_ready_o;
    logic              cmd_write_i = 1'b0;
    logic [31:0]       cmd_addr_i = '0;
    logic [31:0]       cmd_wdata_i = '0;
    logic [3:0]        cmd_wstrb_i = '0;
    logic              rsp_valid_o;
    logic              rsp_ready_i = 1'b0;
    logic [31:0]       rsp_rdata_o;
    logic [1:0]        rsp_resp_o;
    logic              rsp_timeout_o;
    logic [31:0]       awaddr_o;
    logic              awvalid_o;
    logic              awready_i;
    logic [31:0]       wdata_o;
    logic [3:0]        wstrb_o;
    logic              wvalid_o;
    logic              wready_i;
    logic [1:0]        bresp_i;
    logic              bvalid_i;
    logic              bready_o;
    logic [31:0]       araddr_o;
    logic              arvalid_o;
    logic              arready_i;
    logic [31:0]       rdata_i;
    logic [1:0]        rresp_i;
    logic              rvalid_i;
    logic              rready_o;
    m_axi_cmd_state_t  dbg_state;

    m_axi_cmd #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .areset(areset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_resp_o(rsp_resp_o), .rsp_timeout_o(rsp_timeout_o),
        .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- slave environment (acts on falling edges) ----------------
    int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
    bit          aw_have, w_have, ar_have, r_never;
    bit          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_wstrb;
    logic [31:0] s_waddr, s_wdata, s_raddr;
    logic [3:0]  s_wstrb;
    logic [31:0] s_mem [5];

    initial begin : slave
        awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = 0;
        arready_i = 0; rvalid_i = 0; rdata_i = 0; rresp_i = 0;
        for (int i = 0; i < 5; i++) s_mem[i] = '0;
        forever begin
            @(negedge clk);
            if (areset) begin
                awready_i = 0; wready_i = 0; bvalid_i = 0; arready_i = 0; rvalid_i = 0;
                aw_have = 0; w_have = 0; ar_have = 0;
                aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
            end else begin
                // consequences of transfers at the previous rising edge
                if (aw_hs) begin aw_hs = 0; aw_have = 1; awready_i = 0; end
                if (w_hs)  begin w_hs = 0;  w_have = 1;  wready_i = 0;  end
                if (b_hs)  begin b_hs = 0;  bvalid_i = 0; aw_have = 0; w_have = 0; end
                if (ar_hs) begin ar_hs = 0; ar_have = 1; arready_i = 0; end
                if (r_hs)  begin r_hs = 0;  rvalid_i = 0; ar_have = 0; end
                // one beat per channel; the other write channel is unaffected
                if (aw_have) check("awvalid_drop", awvalid_o, 0);
                if (w_have)  check("wvalid_drop", wvalid_o, 0);
                if (ar_have) check("arvalid_drop", arvalid_o, 0);
                if (aw_have && !w_have) check("wvalid_hold", wvalid_o, 1);
                if (w_have && !aw_have) check("awvalid_hold", awvalid_o, 1);
                if (awvalid_o && !aw_have && !awready_i) begin
                    if (aw_wait == 0) begin
                        awready_i = 1;
                        check("awaddr", awaddr_o, cur_addr);
                        s_waddr = awaddr_o;
                    end else aw_wait--;
                end
                if (wvalid_o && !w_have && !wready_i) begin
                    if (w_wait == 0) begin
                        wready_i = 1;
                        check("wdata_wstrb", {wstrb_o, wdata_o}, {cur_wstrb, cur_wdata});
                        s_wdata = wdata_o;
                        s_wstrb = wstrb_o;
                    end else w_wait--;
                end
                if (aw_have && w_have && !bvalid_i) begin
                    if (b_wait == 0) begin
                        if (s_waddr < 32'h14) begin
                            for (int b = 0; b < 4; b++)
                                if (s_wstrb[b]) s_mem[s_waddr >> 2][8*b +: 8] = s_wdata[8*b +: 8];
                            bresp_i = 2'd0;
                        end else bresp_i = 2'd2;
                        bvalid_i = 1;
                    end else b_wait--;
                end
                if (arvalid_o && !ar_have && !arready_i) begin
                    if (ar_wait == 0) begin
                        arready_i = 1;
                        check("araddr", araddr_o, cur_addr);
                        s_raddr = araddr_o;
                    end else ar_wait--;
                end
                if (ar_have && !rvalid_i && !r_never) begin
                    if (r_wait == 0) begin
                        if (s_raddr < 32'h14) begin
                            rdata_i = s_mem[s_raddr >> 2];
                            rresp_i = 2'd0;
                        end else begin
                            rdata_i = '0;
                            rresp_i = 2'd2;
                        end
                        rvalid_i = 1;
                    end else r_wait--;
                end
                // transfers that will complete at the next rising edge
                aw_hs = awvalid_o && awready_i;
                w_hs  = wvalid_o && wready_i;
                b_hs  = bvalid_i && bready_o;
                ar_hs = arvalid_o && arready_i;
                r_hs  = rvalid_i && rready_o;
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [31:0] exp_mem [5];
    logic [33:0] exp_q [$];

    task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_d, input int w_d, input int b_d,
                          input int ar_d, input int r_d, input int hold);
        logic [33:0] exp, got;
        logic        got_to;
        int          exp_lat, lat, n, idx;
        idx = int'(addr >> 2);
        if (wr) begin
            if (addr < 32'h14) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) exp_mem[idx][8*b +: 8] = data[8*b +: 8];
                exp = {2'd0, 32'd0};
            end else exp = {2'd2, 32'd0};
            exp_lat = 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d;
        end else begin
            exp = (addr < 32'h14) ? {2'd0, exp_mem[idx]} : {2'd2, 32'd0};
            exp_lat = 3 + ar_d + r_d;
        end
        exp_q.push_back(exp);
        cur_addr = addr; cur_wdata = data; cur_wstrb = strb;
        aw_wait = aw_d; w_wait = w_d; b_wait = b_d; ar_wait = ar_d; r_wait = r_d;

        @(negedge clk);
        cmd_valid_i = 1; cmd_write_i = wr; cmd_addr_i = addr;
        cmd_wdata_i = data; cmd_wstrb_i = strb;
        n = 0;
        while (!cmd_ready_o && n < 50) begin @(negedge clk); n++; end
        check("cmd_ready", cmd_ready_o, 1);
        @(negedge clk);
        cmd_valid_i = 0;
        lat = 1;
        while (!rsp_valid_o && lat < 200) begin @(negedge clk); lat++; end
        check("rsp_valid", rsp_valid_o, 1);
        check("latency", lat, exp_lat);
        check("busy_no_ready", cmd_ready_o, 0);
        got = {rsp_resp_o, rsp_rdata_o};
        got_to = rsp_timeout_o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("rsp_stable", {rsp_valid_o, rsp_resp_o, rsp_rdata_o}, {1'b1, got});
            check("hold_no_accept", cmd_ready_o, 0);
        end
        rsp_ready_i = 1;
        @(negedge clk);
        rsp_ready_i = 0;
        check("rsp_drop", rsp_valid_o, 0);
        check("ready_again", cmd_ready_o, 1);
        exp = exp_q.pop_front();
        check(wr ? "wr_rsp" : "rd_rsp", got, exp);
        check("rsp_timeout", got_to, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int seen, lat;
        logic [31:0] rnd;
        for (int i = 0; i < 5; i++) exp_mem[i] = '0;
        cur_addr = '0; cur_wdata = '0; cur_wstrb = '0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready_o, 1);
        check("rst_valids", {awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, rsp_valid_o}, 0);
        check("rst_rsp", {rsp_resp_o, rsp_rdata_o, rsp_timeout_o}, 0);
        check("rst_addr_data", {awaddr_o, araddr_o, wdata_o, wstrb_o}, 0);
        check("rst_state", dbg_state, ST_IDLE);
        areset = 0;
        @(negedge clk);
        check("idle_ready", cmd_ready_o, 1);

        // directed cases
        do_cmd(1, 32'h0, 32'h0000_0001, 4'hF, 0, 0, 0, 0, 0, 0);
        do_cmd(1, 32'h8, 32'h1234_5678, 4'hF, 0, 3, 0, 0, 0, 0);
        do_cmd(1, 32'hC, 32'hAABB_CCDD, 4'hF, 3, 0, 2, 0, 0, 1);
        do_cmd(1, 32'h14, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 0, 0, 0);
        do_cmd(0, 32'h14, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0);
        do_cmd(1, 32'h4, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 0);
        do_cmd(0, 32'h4, 32'h0, 4'h0, 0, 0, 0, 0, 0, 5);
        do_cmd(1, 32'h4, 32'h0000_5500, 4'h2, 1, 1, 1, 0, 0, 0);
        do_cmd(0, 32'h4, 32'h0, 4'h0, 0, 0, 0, 2, 3, 2);

        // reset in the middle of a write
        cur_addr = 32'h10; cur_wdata = 32'hCAFE_F00D; cur_wstrb = 4'hF;
        aw_wait = 20; w_wait = 20; b_wait = 0;
        @(negedge clk);
        cmd_valid_i = 1; cmd_write_i = 1; cmd_addr_i = 32'h10;
        cmd_wdata_i = 32'hCAFE_F00D; cmd_wstrb_i = 4'hF;
        @(negedge clk);
        cmd_valid_i = 0;
        check("pre_rst_awvalid", awvalid_o, 1);
        #2 areset = 1;
        #1;
        check("async_rst_awvalid", awvalid_o, 0);
        check("async_rst_wvalid", wvalid_o, 0);
        check("async_rst_cmd_ready", cmd_ready_o, 1);
        @(negedge clk);
        @(negedge clk);
        areset = 0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid_o) seen++;
        end
        check("no_rsp_after_rst", seen, 0);

`ifdef M_AXI_CMD_TIMEOUT_EN
        // slave never returns read data
        r_never = 1; cur_addr = 32'h8; ar_wait = 0;
        @(negedge clk);
        cmd_valid_i = 1; cmd_write_i = 0; cmd_addr_i = 32'h8;
        @(negedge clk);
        cmd_valid_i = 0;
        lat = 1;
        while (!rsp_valid_o && lat < 100) begin @(negedge clk); lat++; end
        check("to_rsp_valid", rsp_valid_o, 1);
        check("to_latency", lat, 1 + TO);
        check("to_resp", rsp_resp_o, 3);
        check("to_flag", rsp_timeout_o, 1);
        check("to_rready", rready_o, 0);
        check("to_arvalid", arvalid_o, 0);
        rsp_ready_i = 1;
        @(negedge clk);
        rsp_ready_i = 0;
        check("to_rsp_drop", rsp_valid_o, 0);
        r_never = 0; ar_have = 0;
`endif

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            rnd = $urandom;
            do_cmd(rnd[0], 32'($urandom_range(0, 5)) << 2, $urandom, rnd[4:1],
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // final sweep of every in-range word
        for (int a = 0; a < 5; a++)
            do_cmd(0, 32'(a * 4), 32'h0, 4'h0, 0, 0, 0, 0, 0, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
